// File: rtl/atm_keypad_entry_pkg.sv
// Shared key codes, entry modes and FSM state encodings for the ATM keypad entry block.
package atm_keypad_entry_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_BKSP   = 4'hB;
  localparam logic [3:0] KEY_ENTER  = 4'hC;
  localparam logic [3:0] KEY_CANCEL = 4'hD;

  localparam logic MODE_PIN    = 1'b0;
  localparam logic MODE_AMOUNT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_bcd_converter.sv
// Serial BCD-to-binary engine: one nibble per cycle, most significant held digit first.
module keypad_bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] digits,
  input  logic [2:0]  count,
  output logic [15:0] result,
  output logic        done
);

  logic        vld_p0;
  logic [2:0]  rem_p0;
  logic [15:0] sh_p0;
  logic [15:0] acc_p0;

  // Left-justify the held digits so the oldest one sits in the top nibble.
  function automatic logic [15:0] align_digits(input logic [15:0] d, input logic [2:0] n);
    case (n)
      3'd1:    align_digits = {d[3:0], 12'h000};
      3'd2:    align_digits = {d[7:0], 8'h00};
      3'd3:    align_digits = {d[11:0], 4'h0};
      default: align_digits = d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      rem_p0 <= 3'd0;
    end else if (start) begin
      vld_p0 <= (count != 3'd0);
      rem_p0 <= count;
    end else if (vld_p0) begin
      vld_p0 <= (rem_p0 != 3'd1);
      rem_p0 <= rem_p0 - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0 <= 16'd0;
      sh_p0  <= align_digits(digits, count);
    end else if (vld_p0) begin
      acc_p0 <= result;
      sh_p0  <= {sh_p0[11:0], 4'h0};
    end
  end

  // acc*10 as (acc<<3)+(acc<<1); the last step is presented combinationally with done.
  assign result = (acc_p0 << 3) + (acc_p0 << 1) + {12'h000, sh_p0[15:12]};
  assign done   = vld_p0 && (rem_p0 == 3'd1);

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry front end: collects PIN (packed BCD) or amount (binary) entries.
// Optional inactivity abort enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry
  import atm_keypad_entry_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_start,
  input  logic        mode,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        cancelled,
  output logic        timeout,
  output logic        entry_error,
  output logic [2:0]  digit_count,
  output logic        busy
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("atm_keypad_entry: parameter out of range");
  end

  state_t      state, state_nxt;
  logic        mode_r;
  logic [15:0] digits;
  logic        restart, push, clr, pop, key_err, cancel_hit, pin_done, conv_start, tmo_hit;
  logic        conv_done;
  logic [15:0] conv_result;

  keypad_bcd_converter u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .digits (digits),
    .count  (digit_count),
    .result (conv_result),
    .done   (conv_done)
  );

`ifdef KEYPAD_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || key_valid) idle_cnt <= 16'd0;
    else if (state == COLLECT)       idle_cnt <= idle_cnt + 16'd1;
  end

  assign tmo_hit = (state == COLLECT) && !entry_start && !key_valid &&
                   (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (entry_start) state_nxt = COLLECT;
      COLLECT: begin
        if (restart)                 state_nxt = COLLECT;
        else if (tmo_hit)            state_nxt = IDLE;
        else if (cancel_hit)         state_nxt = IDLE;
        else if (pin_done)           state_nxt = DONE;
        else if (conv_start)         state_nxt = CONVERT;
      end
      CONVERT: if (conv_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Key decode is only live in COLLECT; a simultaneous entry_start wins over the key.
  always_comb begin
    restart    = entry_start && (state == IDLE || state == COLLECT);
    push       = 1'b0;
    clr        = 1'b0;
    pop        = 1'b0;
    key_err    = 1'b0;
    cancel_hit = 1'b0;
    pin_done   = 1'b0;
    conv_start = 1'b0;
    if (state == COLLECT && !entry_start && key_valid) begin
      if (key_code <= 4'h9) begin
        push    = (digit_count < MAX_CNT);
        key_err = !(digit_count < MAX_CNT);
      end else begin
        case (key_code)
          KEY_CLEAR:  clr = 1'b1;
          KEY_BKSP: begin
            pop     = (digit_count != 3'd0);
            key_err = (digit_count == 3'd0);
          end
          KEY_ENTER: begin
            if (mode_r == MODE_PIN) begin
              pin_done = (digit_count == MAX_CNT);
              key_err  = (digit_count != MAX_CNT);
            end else begin
              conv_start = (digit_count != 3'd0);
              key_err    = (digit_count == 3'd0);
            end
          end
          KEY_CANCEL: cancel_hit = 1'b1;
          default:    ;
        endcase
      end
    end
    value_valid = (state == DONE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= 16'h0000;
      digit_count <= 3'd0;
      value       <= 16'h0000;
      mode_r      <= MODE_PIN;
      entry_error <= 1'b0;
      cancelled   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      entry_error <= key_err;
      cancelled   <= cancel_hit;
      timeout     <= tmo_hit;
      if (restart) begin
        digits      <= 16'h0000;
        digit_count <= 3'd0;
        mode_r      <= mode;
      end else if (push) begin
        digits      <= {digits[11:0], key_code};
        digit_count <= digit_count + 3'd1;
      end else if (clr) begin
        digits      <= 16'h0000;
        digit_count <= 3'd0;
      end else if (pop) begin
        digits      <= {4'h0, digits[15:4]};
        digit_count <= digit_count - 3'd1;
      end
      if (pin_done)                          value <= digits;
      else if (state == CONVERT && conv_done) value <= conv_result;
    end
  end

endmodule
